// File: rtl/sar_adc_pkg.sv
// Shared types and default sizes for the SAR ADC controller.
package sar_adc_pkg;

    localparam int ADCBITS_DEF = 10;
    localparam int CNTW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        HOLD
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Sequences sample/convert on an asynchronous SAR ADC and hands each result
// downstream on a valid/ready interface.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int ADCBITS = ADCBITS_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trigger,
    input  logic [CNTW-1:0]    sample_cycles,
    input  logic [CNTW-1:0]    timeout_cycles,
    input  logic [ADCBITS-1:0] adc_dout,
    input  logic               adc_done,
    output logic               sample,
    output logic [ADCBITS-1:0] data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               busy,
    output logic               timeout_err,
    output logic [CNTW-1:0]    dropped_cnt
);

    localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          state_reg;
    logic [CNTW-1:0] count_reg;
    logic            done_s;
    logic [CNTW-1:0] sample_last;
    logic [CNTW-1:0] count_inc;
    logic            timeout_hit;

    // The ADC idles with done high, so the synchronizer resets to 1.
    sync_2ff #(.RESET_VAL(1'b1)) u_done_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (adc_done),
        .q       (done_s)
    );

    assign sample_last = (sample_cycles == '0) ? '0 : sample_cycles - ONE;
    assign count_inc   = (count_reg == '1) ? count_reg : count_reg + ONE;
    assign timeout_hit = (timeout_cycles != '0) && (count_reg >= timeout_cycles);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            sample      <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            timeout_err <= 1'b0;

            if (trigger && (state_reg != IDLE) && (dropped_cnt != '1))
                dropped_cnt <= dropped_cnt + ONE;

            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        state_reg <= SAMPLE;
                        sample    <= 1'b1;
                        busy      <= 1'b1;
                        count_reg <= '0;
                    end
                end
                SAMPLE: begin
                    count_reg <= count_inc;
                    // done_s low proves the ADC saw sample rise before we drop it.
                    if ((count_reg >= sample_last) && !done_s) begin
                        state_reg <= CONVERT;
                        sample    <= 1'b0;
                        count_reg <= '0;
                    end else if (done_s && timeout_hit) begin
                        state_reg   <= IDLE;
                        sample      <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        count_reg   <= '0;
                    end
                end
                CONVERT: begin
                    count_reg <= count_inc;
                    if (done_s) begin
                        state_reg  <= HOLD;
                        data_out   <= adc_dout;
                        data_valid <= 1'b1;
                        count_reg  <= '0;
                    end else if (timeout_hit) begin
                        state_reg   <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        count_reg   <= '0;
                    end
                end
                HOLD: begin
                    if (data_ready) begin
                        state_reg  <= IDLE;
                        data_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    sample     <= 1'b0;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                    count_reg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: behavioural SAR ADC (vref = 1000 mV) plus directed
// and randomized conversions checked against an ideal-code reference.
`timescale 1ns/1ps
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       trigger = 1'b0;
    logic [7:0] sample_cycles = 8'd4;
    logic [7:0] timeout_cycles = 8'd0;
    logic [9:0] adc_dout = '0;
    logic       adc_done = 1'b1;
    logic       sample;
    logic [9:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       busy;
    logic       timeout_err;
    logic [7:0] dropped_cnt;

    int vectors = 0;
    int miscompares = 0;

    sar_adc_ctrl #(.ADCBITS(10), .CNTW(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trigger        (trigger),
        .sample_cycles  (sample_cycles),
        .timeout_cycles (timeout_cycles),
        .adc_dout       (adc_dout),
        .adc_done       (adc_done),
        .sample         (sample),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .dropped_cnt    (dropped_cnt)
    );

    always #5 clk = ~clk;

    // Ideal transfer function of the ADC: floor(vin/vref * 1023).
    function automatic logic [9:0] ideal_code(int mv);
        return 10'((mv * 1023) / 1000);
    endfunction

    // Behavioural ADC: done falls shortly after sample rises, and the result
    // appears together with done a conversion delay after sample falls.
    int vin_mv = 500;
    int held_mv = 0;
    int conv_dly_ns = 40;
    bit stuck_high = 1'b0;
    bit stuck_low = 1'b0;

    always @(posedge sample) begin
        #3;
        if (!stuck_high) adc_done = 1'b0;
    end

    always @(negedge sample) begin
        held_mv  = vin_mv;
        adc_dout = 10'($urandom);
        #(conv_dly_ns);
        if (!stuck_low) begin
            adc_dout = ideal_code(held_mv);
            adc_done = 1'b1;
        end
    end

    // Observation of the output side, sampled on the inactive edge.
    logic [9:0] acc_q[$];
    int accept_cnt = 0;
    int to_cnt = 0;
    int valid_cycles = 0;
    int sample_run = 0;
    int last_sample_len = 0;
    int idle_run = 0;
    int last_idle_run = 0;

    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            acc_q.push_back(data_out);
            accept_cnt++;
        end
        if (timeout_err) to_cnt++;
        if (data_valid) valid_cycles++;
        if (sample) sample_run++;
        else if (sample_run != 0) begin
            last_sample_len = sample_run;
            sample_run = 0;
        end
        if (!busy) idle_run++;
        else begin
            if (idle_run != 0) last_idle_run = idle_run;
            idle_run = 0;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(string tag, int val, int lo, int hi);
        chk(tag, 32'((val >= lo) && (val <= hi)), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int i = 0;
        while (busy && i < budget) begin
            step();
            i++;
        end
        chk("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(int budget);
        int i = 0;
        while (!data_valid && i < budget) begin
            step();
            i++;
        end
        chk("valid_bound", 32'(data_valid), 32'd1);
    endtask

    task automatic wait_accepts(int n, int budget);
        int i = 0;
        while (accept_cnt < n && i < budget) begin
            step();
            i++;
        end
        chk("accept_bound", 32'(accept_cnt >= n), 32'd1);
    endtask

    int model_drops = 0;
    int base_acc, base_to, base_valid;
    logic [9:0] exp_word;

    initial begin
        // Reset state
        step();
        step();
        chk("rst_sample", 32'(sample), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_dropped", 32'(dropped_cnt), 0);
        #3 reset_n = 1'b1;
        step();

        // Basic conversion, vin = 0.5 * vref
        base_acc = accept_cnt; base_valid = valid_cycles;
        vin_mv = 500; sample_cycles = 4; timeout_cycles = 0; data_ready = 1'b1;
        pulse_trigger();
        chk("basic_busy", 32'(busy), 1);
        wait_accepts(base_acc + 1, 200);
        step();
        chk("basic_word", 32'(acc_q[$]), 32'h1FF);
        chk("basic_count", 32'(accept_cnt - base_acc), 1);
        chk("basic_valid_len", 32'(valid_cycles - base_valid), 1);
        chk_range("basic_sample_len", last_sample_len, 4, 7);
        chk("basic_idle", 32'(busy), 0);

        // Backpressure: ready held low for 20 cycles
        data_ready = 1'b0; vin_mv = 333; exp_word = ideal_code(333);
        base_acc = accept_cnt;
        pulse_trigger();
        wait_valid(200);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_valid_held", 32'(data_valid), 1);
            chk("bp_data_held", 32'(data_out), 32'(exp_word));
        end
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        step();
        chk("bp_one_accept", 32'(accept_cnt - base_acc), 1);
        chk("bp_word", 32'(acc_q[$]), 32'(exp_word));
        chk("bp_valid_clear", 32'(data_valid), 0);
        chk("bp_idle", 32'(busy), 0);
        data_ready = 1'b1;

        // Dropped triggers during one long conversion
        sample_cycles = 20; base_acc = accept_cnt; vin_mv = 100;
        pulse_trigger();
        for (int i = 0; i < 5; i++) begin
            chk("drop_busy", 32'(busy), 1);
            trigger = 1'b1;
            if (busy) model_drops++;
            step();
            trigger = 1'b0;
            step();
        end
        wait_idle(300);
        chk("drop_count5", 32'(dropped_cnt), 32'(model_drops));
        chk("drop_one_word", 32'(accept_cnt - base_acc), 1);
        chk("drop_word", 32'(acc_q[$]), 32'(ideal_code(100)));

        // Saturation of the dropped counter
        sample_cycles = 4;
        for (int i = 0; i < 4000 && model_drops < 300; i++) begin
            trigger = !trigger;
            if (trigger && busy) model_drops++;
            step();
        end
        trigger = 1'b0;
        step();
        wait_idle(200);
        chk("drop_sat", 32'(dropped_cnt), 32'((model_drops > 255) ? 255 : model_drops));

        // Done never falls: timeout in SAMPLE
        stuck_high = 1'b1; timeout_cycles = 10;
        base_acc = accept_cnt; base_to = to_cnt; base_valid = valid_cycles;
        pulse_trigger();
        wait_idle(100);
        step();
        chk("tos_pulses", 32'(to_cnt - base_to), 1);
        chk("tos_no_data", 32'(valid_cycles - base_valid), 0);
        chk("tos_sample_low", 32'(sample), 0);
        chk_range("tos_sample_len", last_sample_len, 10, 12);
        stuck_high = 1'b0;

        // Done never rises: timeout in CONVERT
        stuck_low = 1'b1;
        base_to = to_cnt; base_valid = valid_cycles;
        pulse_trigger();
        wait_idle(200);
        step();
        chk("toc_pulses", 32'(to_cnt - base_to), 1);
        chk("toc_no_data", 32'(valid_cycles - base_valid), 0);
        chk("toc_idle", 32'(busy), 0);
        adc_done = 1'b1; stuck_low = 1'b0; timeout_cycles = 0;
        repeat (5) step();

        // Reset while converting
        conv_dly_ns = 300; vin_mv = 900;
        pulse_trigger();
        for (int i = 0; i < 50 && !(busy && !sample); i++) step();
        chk("rstc_in_convert", 32'(busy && !sample), 1);
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("rstc_sample", 32'(sample), 0);
        chk("rstc_busy", 32'(busy), 0);
        chk("rstc_valid", 32'(data_valid), 0);
        chk("rstc_dropped", 32'(dropped_cnt), 0);
        #3 reset_n = 1'b1;
        model_drops = 0;
        repeat (40) step();
        chk("rstc_no_stale", 32'(data_valid), 0);
        conv_dly_ns = 40; vin_mv = 640; base_acc = accept_cnt;
        pulse_trigger();
        wait_accepts(base_acc + 1, 200);
        chk("rstc_word", 32'(acc_q[$]), 32'(ideal_code(640)));

        // Back-to-back with trigger held high
        wait_idle(50);
        step();
        vin_mv = 250; base_acc = accept_cnt;
        trigger = 1'b1;
        wait_accepts(base_acc + 1, 200);
        vin_mv = 750;
        step();
        trigger = 1'b0;
        wait_accepts(base_acc + 2, 200);
        wait_idle(50);
        chk("b2b_word0", 32'(acc_q[acc_q.size()-2]), 32'h0FF);
        chk("b2b_word1", 32'(acc_q[$]), 32'h2FF);
        chk("b2b_gap", 32'(last_idle_run), 1);

        // Randomized conversions
        for (int n = 0; n < 10; n++) begin
            int k;
            vin_mv = int'($urandom_range(0, 1000));
            sample_cycles = 8'($urandom_range(0, 12));
            conv_dly_ns = int'($urandom_range(15, 90));
            k = int'($urandom_range(0, 5));
            exp_word = ideal_code(vin_mv);
            base_acc = accept_cnt;
            data_ready = 1'b0;
            step();
            pulse_trigger();
            wait_valid(300);
            chk("rnd_data", 32'(data_out), 32'(exp_word));
            chk_range("rnd_sample_len", last_sample_len,
                      (sample_cycles == 0) ? 1 : int'(sample_cycles),
                      ((sample_cycles == 0) ? 1 : int'(sample_cycles)) + 3);
            repeat (k) begin
                step();
                chk("rnd_hold", 32'({data_valid, data_out}), 32'({1'b1, exp_word}));
            end
            data_ready = 1'b1;
            step();
            data_ready = 1'b0;
            step();
            chk("rnd_accept", 32'(accept_cnt - base_acc), 1);
            chk("rnd_word", 32'(acc_q[$]), 32'(exp_word));
            wait_idle(20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Synchronous digital controller for the asynchronous 10-bit SAR ADC. Raises `sample` so the ADC tracks its input, then drops `sample` so the falling edge starts a conversion.
- Waits for the ADC's asynchronous `done`, then latches `dout` and presents the word downstream on a valid/ready handshake.
- Sits between the channel trigger logic and the per-channel event FIFO in the digital core.

Parameters:
- ADCBITS, 10, ADC word width.
- CNTW, 8, width of the sample/timeout cycle counters and the config inputs.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- trigger  input  1  synchronous conversion request, level or pulse; sampled only in IDLE.
- sample_cycles  input  CNTW  minimum track time in clk cycles; 0 is treated as 1.
- timeout_cycles  input  CNTW  maximum wait for each `done` transition; 0 disables the timeout.
- adc_dout  input  ADCBITS  ADC result, asynchronous, stable whenever adc_done is high.
- adc_done  input  1  ADC done, asynchronous; low while sampling, high after conversion.
- sample  output  1  ADC sample command, registered.
- data_out  output  ADCBITS  captured ADC word.
- data_valid  output  1  data_out valid.
- data_ready  input  1  downstream accepts when valid && ready.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  one-cycle pulse on a done timeout.
- dropped_cnt  output  CNTW  saturating count of triggers ignored while busy.

Behaviour:
- Reset (async assert, sync release): state IDLE, sample=0, data_out=0, data_valid=0, busy=0, timeout_err=0, dropped_cnt=0, counters=0, synchronizer flops=1 (the ADC idles with done high).
- adc_done passes through a 2-flop synchronizer to give done_s. Nothing else consumes the raw adc_done.
- adc_dout is captured only on the cycle done_s first reads high in CONVERT. The ADC updates done and dout with the same delay, so dout is stable by then. adc_dout needs no synchronizer.
- FSM:
  - IDLE: if trigger, go to SAMPLE next cycle, sample<=1, count<=0.
  - SAMPLE: sample=1, count increments each cycle.
    - Leave when count >= max(sample_cycles,1)-1 AND done_s==0; then sample<=0, count<=0, go to CONVERT.
    - done_s==0 confirms the ADC has seen the rising edge. The FSM waits for it before dropping sample.
    - If timeout enabled and count reaches timeout_cycles with done_s still 1: timeout_err pulse, sample<=0, go to IDLE.
  - CONVERT: sample=0, count increments.
    - On done_s==1: data_out<=adc_dout, data_valid<=1, go to HOLD.
    - On timeout: timeout_err pulse, go to IDLE with no data.
  - HOLD: data_valid=1, data_out stable. On data_ready, clear data_valid and go to IDLE the same cycle. Ready may be high on the first HOLD cycle.
- Latency: with sample_cycles=N (N>=2), data_valid asserts N+(2..3 sync cycles)+ADC delay after trigger is seen.
- Minimum spacing between conversions is one IDLE cycle after the handshake.
- dropped_cnt increments when trigger=1 in any non-IDLE state. It saturates at 2^CNTW-1 and clears only on reset.
- busy is registered and equals (state != IDLE).
- Reset mid-operation: all outputs return to reset values immediately; the ADC's in-flight result is discarded.
- A trigger held high re-fires as soon as IDLE is re-entered.

Decomposition:
- Shared package sar_adc_pkg: state enum typedef (IDLE, SAMPLE, CONVERT, HOLD), ADCBITS default constant.
- One natural sub-module: sync_2ff (generic 2-flop synchronizer, reset value parameter) for adc_done.

Test Plan:
- Basic conversion: ADC model with vref=1.0, vcm=0.0, vin=0.5, sample_cycles=4, timeout=0, ready=1; pulse trigger -> sample high 4+ cycles, then one word data_out=0x1FF with data_valid for one cycle; busy then falls.
- Backpressure: ready=0 for 20 cycles after valid -> data_valid and data_out held constant; a 1-cycle ready produces exactly one accept, then IDLE.
- Dropped triggers: 5 trigger pulses during one conversion -> dropped_cnt=5, only one word output; 300 such pulses -> dropped_cnt saturates at 255.
- Done timeout: adc_done tied high, timeout_cycles=10 -> timeout_err pulses exactly once about 10 cycles into SAMPLE, sample returns to 0, no data_valid.
- Done timeout in CONVERT: done forced low after sample falls -> timeout_err pulses exactly once in CONVERT, FSM returns to IDLE, no data_valid.
- Reset mid-conversion: assert reset_n=0 while in CONVERT -> sample, busy, data_valid go 0 asynchronously. After release and a new trigger, the next result is correct.
- Back-to-back: trigger held high, ready=1, vin stepped 0.25 -> 0.75 -> consecutive words 0x0FF and 0x2FF, one IDLE cycle between them.
